novacore_cfg_loader: RTL and testbench

NOVACORE_CFG_LOADER -- requirements
Module: novacore_cfg_loader

---
 rtl/novacore_cfg_loader.sv | 187 ++++++++++++++++++
 tb/tb_novacore_cfg_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/novacore_cfg_loader.sv
// ============================================================================
// novacore_cfg_loader
//   Streams configuration words into a fabric of CELLS cells. Each accepted
//   word is presented on c_bus/c_uid, followed by one setup cycle and one
//   c_clk pulse (CLK_DIV cycles high, CLK_DIV cycles low). In broadcast mode
//   a single word is sent to the all-ones cell address.
//
//   Optional feature macro: NOVACORE_CFG_CHECKSUM_EN
//     Adds a CHECK state. After the last cell word, one more word is taken
//     from the stream and compared with the XOR of all accepted words. A
//     mismatch sets err and leaves mode asserted after done.
//
// Ports
//   clk, rst_n        sole clock, asynchronous active-low reset
//   start, broadcast  begin a load (broadcast sampled together with start)
//   abort             cancel a load in progress (sets err)
//   s_data/s_valid/s_ready   configuration word stream in
//   mode              1 while the fabric is held in configuration
//   c_bus, c_uid      word and target cell address to the fabric
//   c_clk             configuration strobe to the fabric
//   busy, done, err   status: load active, one-cycle completion, sticky error
//   words_loaded      number of words fully clocked into the fabric
// ============================================================================
module novacore_cfg_loader #(
    parameter int CELLS   = 81,
    parameter int WORD_W  = 74,
    parameter int UID_W   = 9,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              broadcast,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mode,
    output logic [WORD_W-1:0] c_bus,
    output logic [UID_W-1:0]  c_uid,
    output logic              c_clk,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [UID_W-1:0]  words_loaded
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        PULSE_HI,
        PULSE_LO,
`ifdef NOVACORE_CFG_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t            state, next_state;
    logic [CW-1:0]     div_cnt;
    logic [UID_W-1:0]  cell_idx;
    logic [UID_W-1:0]  total;
    logic              bcast_q;
    logic              div_done;
    logic              last_word;
    logic              abort_hit;
    logic              cnt_run;
    logic              chk_bad;

    assign words_loaded = cell_idx;
    assign total        = bcast_q ? UID_W'(1) : UID_W'(CELLS);
    assign div_done     = (div_cnt == DIV_LAST);
    assign last_word    = ((cell_idx + UID_W'(1)) >= total);
    assign abort_hit    = abort && (state != IDLE);
    // Counter only runs while staying inside a pulse phase; any phase
    // change (or abort) restarts it from zero.
    assign cnt_run      = (next_state == state) &&
                          ((state == PULSE_HI) || (state == PULSE_LO));

`ifdef NOVACORE_CFG_CHECKSUM_EN
    logic [WORD_W-1:0] xor_acc;
    assign s_ready = (state == LOAD) || (state == CHECK);
    assign chk_bad = (state == CHECK) && s_valid && (s_data != xor_acc);
`else
    assign s_ready = (state == LOAD);
    assign chk_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = LOAD;
            LOAD:     if (s_valid) next_state = SETUP;
            SETUP:    next_state = PULSE_HI;
            PULSE_HI: if (div_done) next_state = PULSE_LO;
            PULSE_LO: begin
                if (div_done) begin
                    if (!last_word) next_state = LOAD;
`ifdef NOVACORE_CFG_CHECKSUM_EN
                    else            next_state = CHECK;
`else
                    else            next_state = DONE;
`endif
                end
            end
`ifdef NOVACORE_CFG_CHECKSUM_EN
            CHECK:    if (s_valid) next_state = DONE;
`endif
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (abort_hit) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_clk    <= 1'b0;
            done     <= 1'b0;
            div_cnt  <= '0;
            mode     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            cell_idx <= '0;
            bcast_q  <= 1'b0;
            c_bus    <= '0;
            c_uid    <= '0;
`ifdef NOVACORE_CFG_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else begin
            // Registered from the next state so c_clk is glitch-free and
            // exactly tracks the PULSE_HI residency.
            c_clk   <= (next_state == PULSE_HI);
            done    <= (next_state == DONE);
            div_cnt <= cnt_run ? div_cnt + CW'(1) : '0;

            if (abort_hit) begin
                mode <= 1'b0;
                busy <= 1'b0;
                err  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mode     <= 1'b1;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            cell_idx <= '0;
                            bcast_q  <= broadcast;
`ifdef NOVACORE_CFG_CHECKSUM_EN
                            xor_acc  <= '0;
`endif
                        end
                    end
                    LOAD: begin
                        if (s_valid) begin
                            c_bus <= s_data;
                            c_uid <= bcast_q ? '1 : cell_idx;
`ifdef NOVACORE_CFG_CHECKSUM_EN
                            xor_acc <= xor_acc ^ s_data;
`endif
                        end
                    end
                    PULSE_LO: if (div_done) cell_idx <= cell_idx + UID_W'(1);
                    default: ;
                endcase
                // busy drops as DONE is entered; mode stays up only if the
                // load ended with an error (checksum mismatch).
                if (next_state == DONE) begin
                    busy <= 1'b0;
                    mode <= err | chk_bad;
                    err  <= err | chk_bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_novacore_cfg_loader.sv
module tb_novacore_cfg_loader;

    localparam int W = 74;
    localparam int U = 9;
    localparam int D = 2;
`ifdef NOVACORE_CFG_CHECKSUM_EN
    localparam int TB_CELLS = 4;
`else
    localparam int TB_CELLS = 81;
`endif

    logic         clk, rst_n, start, broadcast, abort, s_valid;
    logic [W-1:0] s_data;
    logic         s_ready, mode, c_clk, busy, done, err;
    logic [W-1:0] c_bus;
    logic [U-1:0] c_uid, words_loaded;

    novacore_cfg_loader #(.CELLS(TB_CELLS), .WORD_W(W), .UID_W(U), .CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .broadcast(broadcast),
        .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mode(mode), .c_bus(c_bus), .c_uid(c_uid), .c_clk(c_clk),
        .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [U-1:0] uid;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   cut_ok = 0;
    bit   prev_clk = 0;
    int   hi_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: every rising c_clk pops one expected word.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_clk = 0;
            hi_cnt   = 0;
        end else begin
            if (c_clk && !prev_clk) begin
                chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    chk("c_uid", 128'(c_uid), 128'(cur.uid));
                    chk("c_bus", 128'(c_bus), 128'(cur.data));
                end
                hi_cnt = 1;
            end else if (c_clk) begin
                hi_cnt++;
            end else if (prev_clk && !cut_ok) begin
                chk("hi_width", 128'(hi_cnt), 128'(D));
                chk("bus_hold", 128'(c_bus), 128'(cur.data));
                chk("uid_hold", 128'(c_uid), 128'(cur.uid));
            end
            prev_clk = c_clk;
        end
    end

    task automatic do_start(input logic bc);
        cut_ok = 0;
        @(negedge clk);
        start = 1'b1; broadcast = bc;
        @(posedge clk); #1;
        start = 1'b0; broadcast = 1'b0;
        @(negedge clk);
        chk("start_busy", 128'(busy), 128'(1));
        chk("start_mode", 128'(mode), 128'(1));
        chk("start_err", 128'(err), 128'(0));
        chk("start_wl", 128'(words_loaded), 128'(0));
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic [U-1:0] uid, input bit gap);
        int n;
        exp_t e;
        n = 0;
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        chk("ready_timeout", 128'(n < 200), 128'(1));
        s_data = d; s_valid = 1'b1;
        e.uid = uid; e.data = d;
        sb.push_back(e);
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (gap) begin
            n = 1;
            @(negedge clk);
            while (!s_ready && n < 100) begin @(negedge clk); n++; end
            chk("ready_gap", 128'(n), 128'(2 + 2 * D));
        end
    endtask

    task automatic send_check(input logic [W-1:0] d);
        int n;
        n = 0;
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        chk("chk_ready_timeout", 128'(n < 200), 128'(1));
        s_data = d; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int wl, input logic m, input logic e);
        int n;
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        chk("done_seen", 128'(done), 128'(1));
        chk("done_busy", 128'(busy), 128'(0));
        chk("done_mode", 128'(mode), 128'(m));
        chk("done_err", 128'(err), 128'(e));
        chk("done_wl", 128'(words_loaded), 128'(wl));
        @(negedge clk);
        chk("done_1cyc", 128'(done), 128'(0));
        chk("sb_drained", 128'(sb.size()), 128'(0));
    endtask

    task automatic run_load(input int stall_at);
        logic [W-1:0] acc, d;
        bit           g;
        acc = '0;
        do_start(1'b0);
        for (int i = 0; i < TB_CELLS; i++) begin
            d = W'(i);
            if (i == stall_at) begin
                // start/broadcast while busy must have no effect
                start = 1'b1; broadcast = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    chk("stall_c_clk", 128'(c_clk), 128'(0));
                    chk("stall_c_bus", 128'(c_bus), 128'(i - 1));
                    chk("stall_c_uid", 128'(c_uid), 128'(i - 1));
                end
                start = 1'b0; broadcast = 1'b0;
            end
`ifdef NOVACORE_CFG_CHECKSUM_EN
            g = 1'b1;
`else
            g = (i != TB_CELLS - 1);
`endif
            send_word(d, U'(i), g);
            acc = acc ^ d;
        end
`ifdef NOVACORE_CFG_CHECKSUM_EN
        send_check(acc);
`endif
        wait_done(TB_CELLS, 1'b0, 1'b0);
    endtask

`ifdef NOVACORE_CFG_CHECKSUM_EN
    task automatic run_chk(input logic [W-1:0] cw, input logic e);
        logic [W-1:0] d;
        do_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            d = W'(1) << i;
            send_word(d, U'(i), 1'b1);
        end
        send_check(cw);
        wait_done(4, e, e);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw;
        rst_n = 1'b0; start = 1'b0; broadcast = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0;
        #3;
        chk("rst_mode", 128'(mode), 128'(0));
        chk("rst_c_bus", 128'(c_bus), 128'(0));
        chk("rst_c_uid", 128'(c_uid), 128'(0));
        chk("rst_c_clk", 128'(c_clk), 128'(0));
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_wl", 128'(words_loaded), 128'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back full load
        run_load(-1);
        // Full load with a 20-cycle stall before word 3
        run_load(3);

        // Broadcast: single word to all-ones address
        do_start(1'b1);
        send_word(W'(10'h3FF), '1, 1'b0);
`ifdef NOVACORE_CFG_CHECKSUM_EN
        send_check(W'(10'h3FF));
`endif
        wait_done(1, 1'b0, 1'b0);
        saw = 0;
        repeat (5) begin @(negedge clk); if (s_ready) saw = 1; end
        chk("bcast_ready_low", 128'(saw), 128'(0));

        // Abort during PULSE_HI of word 5
        if (TB_CELLS > 6) begin
            do_start(1'b0);
            for (int i = 0; i < 5; i++) send_word(W'(i + 100), U'(i), 1'b1);
            send_word(W'(105), U'(5), 1'b0);
            n = 0;
            @(negedge clk);
            while (!c_clk && n < 20) begin @(negedge clk); n++; end
            chk("abort_pulse_seen", 128'(c_clk), 128'(1));
            cut_ok = 1;
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            chk("abort_c_clk", 128'(c_clk), 128'(0));
            chk("abort_mode", 128'(mode), 128'(0));
            chk("abort_busy", 128'(busy), 128'(0));
            chk("abort_err", 128'(err), 128'(1));
            chk("abort_wl", 128'(words_loaded), 128'(5));
            saw = done;
            repeat (6) begin @(negedge clk); if (done) saw = 1; end
            chk("abort_no_done", 128'(saw), 128'(0));
            chk("abort_sb_drained", 128'(sb.size()), 128'(0));
        end

`ifdef NOVACORE_CFG_CHECKSUM_EN
        run_chk(W'(4'hF), 1'b0);
        run_chk(W'(4'hE), 1'b1);
`endif

        // Reset asserted mid-pulse (start also clears the sticky err)
        do_start(1'b0);
        send_word(W'(77), U'(0), 1'b0);
        n = 0;
        @(negedge clk);
        while (!c_clk && n < 20) begin @(negedge clk); n++; end
        chk("rstp_pulse_seen", 128'(c_clk), 128'(1));
        cut_ok = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("rstp_c_clk", 128'(c_clk), 128'(0));
        chk("rstp_mode", 128'(mode), 128'(0));
        chk("rstp_c_bus", 128'(c_bus), 128'(0));
        chk("rstp_c_uid", 128'(c_uid), 128'(0));
        chk("rstp_s_ready", 128'(s_ready), 128'(0));
        chk("rstp_busy", 128'(busy), 128'(0));
        chk("rstp_done", 128'(done), 128'(0));
        chk("rstp_err", 128'(err), 128'(0));
        chk("rstp_wl", 128'(words_loaded), 128'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        repeat (6) begin @(negedge clk); if (c_clk || busy) saw = 1; end
        chk("rstp_no_glitch", 128'(saw), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
